seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL provide parameter PAT_LEN, default 4, pattern length in bits; legal range 2..16.
REQ-002 SHALL provide parameter PATTERN, default 4'b1101, target sequence; MSB is the first bit received.
REQ-003 SHALL provide parameter OVERLAP, default 1; 1 = overlapping detection, 0 = non-overlapping.
REQ-004 SHALL provide parameter MOORE, default 0; 0 = Mealy output, 1 = Moore (registered) output.
REQ-005 SHALL provide parameter CNT_W, default 8, width of the match counter.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-008 SHALL have port en  input  1  sample enable; x is consumed only on edges where en=1.
REQ-009 SHALL have port x  input  1  serial data bit.
REQ-010 SHALL have port clr  input  1  synchronous clear of match_cnt and cnt_sat.
REQ-011 SHALL have port z  output  1  match indication.
REQ-012 SHALL have port match_cnt  output  CNT_W  saturating count of matches.
REQ-013 SHALL have port cnt_sat  output  1  high while match_cnt is all ones.

Function
REQ-014 SHALL track progress as a state value 0..PAT_LEN-1, the number of leading PATTERN bits currently matched.
REQ-015 SHALL, on a mismatching bit, move to the longest proper prefix of PATTERN that is a suffix of the received bits (KMP failure transition), not unconditionally to state 0.
REQ-016 SHALL declare a match when the state is PAT_LEN-1, en=1, and x equals the final PATTERN bit.
REQ-017 SHALL, after a match with OVERLAP=1, move to the longest proper prefix-suffix of PATTERN (state 1 for 1101).
REQ-018 SHALL, after a match with OVERLAP=0, move to state 0.
REQ-019 SHALL, with MOORE=0, drive z combinationally high in the same cycle as the matching x, before the capturing edge.
REQ-020 SHALL, with MOORE=1, drive z from a register: high for exactly the one cycle after the matching edge.
REQ-021 SHALL hold state, and shall drive Mealy z low, while en=0; Moore z shall clear on the first edge with en=0.
REQ-022 SHALL increment match_cnt by 1 on each matching edge.
REQ-023 SHALL stop match_cnt at 2^CNT_W-1; further matches shall still assert z and shall not wrap the counter.
REQ-024 SHALL, when clr=1 and a match occur on the same edge, set match_cnt to 0 (clr wins).
REQ-025 SHALL derive cnt_sat combinationally from match_cnt == all ones.
REQ-026 SHALL ignore x values when en=0, including X/Z values.

Reset
REQ-027 SHALL, on any edge with rst=0, set state to 0, registered z to 0, match_cnt to 0, cnt_sat to 0.
REQ-028 SHALL give rst priority over en, clr, and a simultaneous match; partial progress at reset is discarded.
REQ-029 SHALL drive Mealy z low while rst=0.

Verification
REQ-030 Default params, en=1, x=1,1,0,1,1,0,1 -> z high on bits 4 and 7; match_cnt=2.
REQ-031 OVERLAP=0, same stream -> z high on bit 4 only; match_cnt=1.
REQ-032 MOORE=1, x=1,1,0,1 -> z low during bit 4, high the following cycle only; match_cnt=1 after the bit-4 edge.
REQ-033 Stream 1,1,1,0,1 (KMP fallback) -> match on bit 5; en=0 for 3 cycles inserted between bits 3 and 4 -> same result.
REQ-034 CNT_W=2, 5 overlapping matches of 1101 -> match_cnt stops at 3; cnt_sat=1; z still pulses on matches 4 and 5; clr coincident with match -> match_cnt=0.
REQ-035 rst=0 after x=1,1,0 -> next x=1 gives no match; fresh 1,1,0,1 gives a match.

Source files
------------

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parameterised serial pattern detector with saturating match counter
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-low reset
//   en         sample enable; x is consumed only when en=1
//   x          serial data bit, first bit of PATTERN arrives first
//   clr        synchronous clear of match_cnt
//   z          match indication (Mealy combinational or Moore registered)
//   match_cnt  saturating number of matches
//   cnt_sat    high while match_cnt is all ones

module seq_detect_param #(
    parameter int               PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter bit               OVERLAP = 1,
    parameter bit               MOORE   = 0,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             clr,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int SW  = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
    localparam int TBL = 2 ** (SW + 1);

    // Bit i of the pattern in arrival order (i = 0 is received first).
    function automatic bit pat_bit(input int i);
        return PATTERN[PAT_LEN-1-i];
    endfunction

    // Longest pattern prefix that is a suffix of (first s pattern bits, then b).
    function automatic int longest(input int s, input int b);
        int  best;
        bit  ok;
        bit  r;
        int  p;
        best = 0;
        for (int k = 1; k <= s + 1; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                p = s + 1 - k + j;
                r = (p < s) ? pat_bit(p) : b[0];
                if (r != pat_bit(j)) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

    // Longest proper prefix of the whole pattern that is also its suffix.
    function automatic int border();
        int best;
        bit ok;
        best = 0;
        for (int k = 1; k < PAT_LEN; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (pat_bit(j) != pat_bit(PAT_LEN - k + j)) ok = 1'b0;
            end
            if (ok) best = k;
        end
        return best;
    endfunction

    function automatic int next_val(input int s, input int b);
        if (s >= PAT_LEN) return 0;
        if (s == PAT_LEN - 1 && b == int'(pat_bit(PAT_LEN - 1)))
            return OVERLAP ? border() : 0;
        return longest(s, b);
    endfunction

    // Transition table indexed by {state, x}, fully resolved at elaboration.
    logic [SW-1:0] next_tbl [TBL];

    for (genvar g = 0; g < TBL; g++) begin : g_next
        localparam int NV = next_val(g / 2, g % 2);
        assign next_tbl[g] = NV[SW-1:0];
    end

    logic [SW-1:0] state;
    logic [SW:0]   tbl_idx;
    logic          match;
    logic          z_q;

    assign tbl_idx = {state, x};
    assign match   = rst && en && (state == SW'(PAT_LEN - 1)) && (x == PATTERN[0]);
    assign cnt_sat = &match_cnt;
    assign z       = MOORE ? z_q : match;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= '0;
            z_q       <= 1'b0;
            match_cnt <= '0;
        end else begin
            if (en) state <= next_tbl[tbl_idx];
            z_q <= match;
            if (clr)
                match_cnt <= '0;
            else if (match && !cnt_sat)
                match_cnt <= match_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - self-checking bench for seq_detect_param across four parameter sets

module tb_seq_detect_param;

    logic       clk;
    logic       rst;
    logic       en;
    logic       x;
    logic       clr;

    logic       z0, z1, z2, z3;
    logic [7:0] c0, c1, c2;
    logic [1:0] c3;
    logic       s0, s1, s2, s3;

    int n_cmp;
    int n_fail;
    bit chk_on;

    seq_detect_param u_def (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr(clr),
        .z(z0), .match_cnt(c0), .cnt_sat(s0)
    );

    seq_detect_param #(.OVERLAP(0)) u_nov (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr(clr),
        .z(z1), .match_cnt(c1), .cnt_sat(s1)
    );

    seq_detect_param #(.MOORE(1)) u_moore (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr(clr),
        .z(z2), .match_cnt(c2), .cnt_sat(s2)
    );

    seq_detect_param #(.CNT_W(2)) u_w2 (
        .clk(clk), .rst(rst), .en(en), .x(x), .clr(clr),
        .z(z3), .match_cnt(c3), .cnt_sat(s3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a match is the last four consumed bits reading 1101.
    // Non-overlapping mode restarts the bit history after every match.
    logic [2:0] h_ov, h_nov;
    int         nb_ov, nb_nov;
    int         m_cnt_ov, m_cnt_nov, m_cnt_w2;
    logic       m_moore;
    logic       exp_ov, exp_nov;

    function automatic logic hit(input logic [2:0] h, input int nb, input logic xb,
                                 input logic e, input logic r);
        return r && e && (nb >= 3) && ({h, xb} == 4'b1101);
    endfunction

    assign exp_ov  = hit(h_ov,  nb_ov,  x, en, rst);
    assign exp_nov = hit(h_nov, nb_nov, x, en, rst);

    always @(posedge clk) begin
        if (!rst) begin
            h_ov <= '0; h_nov <= '0; nb_ov <= 0; nb_nov <= 0;
            m_cnt_ov <= 0; m_cnt_nov <= 0; m_cnt_w2 <= 0;
            m_moore <= 1'b0;
        end else begin
            m_moore <= exp_ov;
            if (en) begin
                h_ov  <= {h_ov[1:0], x};
                nb_ov <= (nb_ov < 16) ? nb_ov + 1 : nb_ov;
                if (exp_nov) begin
                    nb_nov <= 0;
                end else begin
                    h_nov  <= {h_nov[1:0], x};
                    nb_nov <= (nb_nov < 16) ? nb_nov + 1 : nb_nov;
                end
            end
            if (clr) begin
                m_cnt_ov <= 0; m_cnt_nov <= 0; m_cnt_w2 <= 0;
            end else begin
                if (exp_ov  && m_cnt_ov  < 255) m_cnt_ov  <= m_cnt_ov + 1;
                if (exp_nov && m_cnt_nov < 255) m_cnt_nov <= m_cnt_nov + 1;
                if (exp_ov  && m_cnt_w2  < 3)   m_cnt_w2  <= m_cnt_w2 + 1;
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("z_def",     int'(z0), int'(exp_ov));
            check("z_nov",     int'(z1), int'(exp_nov));
            check("z_moore",   int'(z2), int'(m_moore));
            check("z_w2",      int'(z3), int'(exp_ov));
            check("cnt_def",   int'(c0), m_cnt_ov);
            check("cnt_nov",   int'(c1), m_cnt_nov);
            check("cnt_moore", int'(c2), m_cnt_ov);
            check("cnt_w2",    int'(c3), m_cnt_w2);
            check("sat_def",   int'(s0), int'(m_cnt_ov == 255));
            check("sat_nov",   int'(s1), int'(m_cnt_nov == 255));
            check("sat_moore", int'(s2), int'(m_cnt_ov == 255));
            check("sat_w2",    int'(s3), int'(m_cnt_w2 == 3));
        end
    end

    task automatic apply(input logic r, input logic e, input logic b, input logic c);
        rst = r; en = e; x = b; clr = c;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            apply(1'b1, 1'b1, v[i], 1'b0);
            tick();
        end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; chk_on = 1'b0;
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        check("rst_cnt", int'(c0), 0);
        check("rst_sat", int'(s0), 0);
        check("rst_z_moore", int'(z2), 0);
        check("rst_z_def", int'(z0), 0);
        chk_on = 1'b1;

        // 1,1,0,1,1,0,1 across overlap, non-overlap and Moore variants
        bits(16'b110, 3);
        apply(1'b1, 1'b1, 1'b1, 1'b0);
        check("b4_z_def", int'(z0), 1);
        check("b4_z_nov", int'(z1), 1);
        check("b4_z_moore", int'(z2), 0);
        tick();
        apply(1'b1, 1'b1, 1'b1, 1'b0);
        check("b5_z_moore", int'(z2), 1);
        check("b5_z_def", int'(z0), 0);
        check("b5_cnt_def", int'(c0), 1);
        check("b5_cnt_moore", int'(c2), 1);
        tick();
        apply(1'b1, 1'b1, 1'b0, 1'b0);
        check("b6_z_moore", int'(z2), 0);
        tick();
        apply(1'b1, 1'b1, 1'b1, 1'b0);
        check("b7_z_def", int'(z0), 1);
        check("b7_z_nov", int'(z1), 0);
        tick();
        check("b7_cnt_def", int'(c0), 2);
        check("b7_cnt_nov", int'(c1), 1);

        // KMP fallback: 1,1,1,0,1
        apply(1'b0, 1'b1, 1'b0, 1'b0); tick();
        bits(16'b1110, 4);
        apply(1'b1, 1'b1, 1'b1, 1'b0);
        check("kmp_z_def", int'(z0), 1);
        tick();

        // Same stream with a three-cycle enable gap between bits 3 and 4
        apply(1'b0, 1'b1, 1'b0, 1'b0); tick();
        bits(16'b111, 3);
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 1'b0, 1'bx, 1'b0);
            check("gap_z_def", int'(z0), 0);
            tick();
        end
        bits(16'b0, 1);
        apply(1'b1, 1'b1, 1'b1, 1'b0);
        check("gap_kmp_z_def", int'(z0), 1);
        tick();

        // Reset discards partial progress even with a would-be match present
        apply(1'b0, 1'b1, 1'b0, 1'b0); tick();
        bits(16'b110, 3);
        apply(1'b0, 1'b1, 1'b1, 1'b0);
        check("rstm_z_def", int'(z0), 0);
        check("rstm_z_w2", int'(z3), 0);
        tick();
        check("rstm_cnt_def", int'(c0), 0);
        apply(1'b1, 1'b1, 1'b1, 1'b0);
        check("post_rst_z_def", int'(z0), 0);
        tick();
        bits(16'b110, 3);
        apply(1'b1, 1'b1, 1'b1, 1'b0);
        check("fresh_z_def", int'(z0), 1);
        tick();

        // Saturation of the 2-bit counter over five overlapping matches
        apply(1'b0, 1'b1, 1'b0, 1'b0); tick();
        bits(16'b1101, 4);
        for (int k = 0; k < 4; k++) begin
            bits(16'b10, 2);
            apply(1'b1, 1'b1, 1'b1, 1'b0);
            check("sat_z_w2", int'(z3), 1);
            tick();
        end
        check("sat_cnt_w2", int'(c3), 3);
        check("sat_flag_w2", int'(s3), 1);
        check("sat_cnt_def", int'(c0), 5);
        check("sat_flag_def", int'(s0), 0);
        bits(16'b10, 2);
        apply(1'b1, 1'b1, 1'b1, 1'b1);
        check("clr_z_w2", int'(z3), 1);
        tick();
        check("clr_cnt_w2", int'(c3), 0);
        check("clr_sat_w2", int'(s3), 0);
        check("clr_cnt_def", int'(c0), 0);

        // Mixed traffic against the model
        for (int k = 0; k < 400; k++) begin
            apply(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
            tick();
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
